// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the integer register-file write port among NREQ write-back units.
// Define RF_WB_SCOREBOARD_EN to add the busy-register scoreboard (alloc_valid/alloc_addr/busy).
module rf_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 64,
    parameter int AW   = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic                 rf_write_enable,
    output logic [AW-1:0]        rf_write_addr,
    output logic [XLEN-1:0]      rf_write_data,
    output logic [2:0]           grant_id
`ifdef RF_WB_SCOREBOARD_EN
    ,
    input  logic                 alloc_valid,
    input  logic [AW-1:0]        alloc_addr,
    output logic [31:0]          busy
`endif
);

    // Returns {found, index} of the first valid requester at or after ptr, wrapping modulo NREQ.
    function automatic logic [3:0] rr_pick(input logic [2:0] ptr, input logic [7:0] vld);
        logic       found;
        logic [2:0] win;
        logic [3:0] sum;
        found = 1'b0;
        win   = 3'd0;
        sum   = 4'd0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + 4'(k);
            sum = (sum >= 4'(NREQ)) ? (sum - 4'(NREQ)) : sum;
            if (!found && vld[sum[2:0]]) begin
                found = 1'b1;
                win   = sum[2:0];
            end else begin
                found = found;
            end
        end
        return {found, win};
    endfunction

    logic [2:0]      rr_ptr_q;
    logic [2:0]      rr_ptr_d;
    logic            found_s;
    logic [2:0]      win_s;
    logic [AW-1:0]   win_addr_s;
    logic [XLEN-1:0] win_data_s;
    logic            we_q;
    logic            we_d;
    logic [AW-1:0]   addr_q;
    logic [AW-1:0]   addr_d;
    logic [XLEN-1:0] data_q;
    logic [XLEN-1:0] data_d;
    logic [2:0]      gid_q;
    logic [2:0]      gid_d;

    assign {found_s, win_s} = rr_pick(rr_ptr_q, 8'(req_valid));

    // Grant decode, winner operand mux and next-state for pointer and output stage.
    always_comb begin
        req_ready  = '0;
        win_addr_s = '0;
        win_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = reset & found_s & (win_s == 3'(i));
            win_addr_s   = (win_s == 3'(i)) ? req_addr[i*AW +: AW]     : win_addr_s;
            win_data_s   = (win_s == 3'(i)) ? req_data[i*XLEN +: XLEN] : win_data_s;
        end
        rr_ptr_d = rr_ptr_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        gid_d    = gid_q;
        if (found_s) begin
            rr_ptr_d = (win_s == 3'(NREQ - 1)) ? 3'd0 : (win_s + 3'd1);
            // A write to x0 is consumed but never reaches the register file.
            if (win_addr_s != '0) begin
                we_d   = 1'b1;
                addr_d = win_addr_s;
                data_d = win_data_s;
                gid_d  = win_s;
            end else begin
                we_d   = 1'b0;
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer and registered write-port stage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= 3'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            gid_q    <= 3'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            gid_q    <= gid_d;
        end
    end

    assign rf_write_enable = we_q;
    assign rf_write_addr   = addr_q;
    assign rf_write_data   = data_q;
    assign grant_id        = gid_q;

`ifdef RF_WB_SCOREBOARD_EN
    logic [31:0] busy_q;
    logic [31:0] busy_d;

    // Busy next-state: retiring write clears, new allocation sets and wins on the same register.
    always_comb begin
        busy_d = busy_q;
        if (we_q) begin
            busy_d[addr_q] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (alloc_valid && (alloc_addr != '0)) begin
            busy_d[alloc_addr] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        busy_d[0] = 1'b0;
    end

    // Busy-register scoreboard state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q <= 32'd0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
`endif

endmodule
